mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter and step sequencer for the `cpu` core. It sits between the core and one shared synchronous memory bus, and serialises each core step's data access (load/store from the MEM stage) and instruction fetch (at `pc`) onto the bus. It holds the core via `stall` until both accesses have completed, then releases it for exactly one cycle. A per-access timeout keeps a dead slave from hanging the core.

## Interface
Parameters:
- XLEN, 32, data/address width
- TIMEOUT, 64, maximum cycles waiting for `bus_ack` per access; 0 disables the timeout
- NOP, 32'h00000013, instruction returned on reset and on fetch timeout

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- pc  in  XLEN  fetch address from the core
- mem_load  in  1  core MEM-stage load request
- mem_store  in  1  core MEM-stage store request
- address  in  XLEN  load/store address
- store_data  in  XLEN  store data
- inst  out  XLEN  fetched instruction, registered, held between steps
- load_data  out  XLEN  load result, registered, held between steps
- stall  out  1  core clock-enable inverse; 1 = core must hold all state
- bus_req  out  1  bus request, registered
- bus_we  out  1  1 = write, registered
- bus_addr  out  XLEN  bus address, registered
- bus_wdata  out  XLEN  bus write data, registered
- bus_ack  in  1  slave completion, sampled only while bus_req=1
- bus_rdata  in  XLEN  read data, valid in the bus_ack cycle
- bus_err  out  1  sticky timeout flag, cleared only by reset

## Operation
- The FSM has four states: START, DATA, FETCH, DONE. Reset enters START.
- START:
  - bus_req=0, stall=1.
  - If mem_load|mem_store, go to DATA and latch bus_addr=address, bus_we=mem_store, bus_wdata=store_data.
  - Otherwise go to FETCH and latch bus_addr=pc, bus_we=0.
- DATA:
  - bus_req=1; bus_addr, bus_we and bus_wdata are stable until ack.
  - On bus_ack: if the access is a load, load_data<=bus_rdata. Then go to FETCH with bus_addr=pc and bus_we=0.
- FETCH:
  - bus_req=1, bus_we=0.
  - On bus_ack: inst<=bus_rdata, then go to DONE.
- DONE:
  - bus_req=0, stall=0 for exactly this cycle; the core advances on this edge.
  - Next state is START.
- mem_load and mem_store both high: the access is treated as a store and load_data is unchanged.
- Store step: load_data is unchanged.
- Inputs are sampled only at START and at the DATA→FETCH transition (pc). The core is stalled at these points, so the inputs are stable.
- Timeout counter:
  - Clears on entry to DATA or FETCH and increments each cycle in which bus_ack=0.
  - When it reaches TIMEOUT-1 with no ack, the access completes as if acked:
    - Load: load_data<=0.
    - Fetch: inst<=NOP.
    - bus_err<=1.
  - Counter width is $clog2(TIMEOUT+1). TIMEOUT=0 disables the counter logic.
- bus_ack while bus_req=0 is ignored.

## Timing
- Reset values: state=START, stall=1, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, inst=NOP, load_data=0, bus_err=0, counter=0.
- Assertion of reset mid-access drops bus_req immediately (asynchronous). A late ack is then ignored.
- bus_req rises the cycle after START and falls the cycle after the sampled ack.
- The core must not assume pipelined acks: one outstanding access at most.
- Step length with zero-wait slave (ack in first req cycle):
  - Fetch-only: 3 cycles (START, FETCH, DONE).
  - Load/store: 4 cycles (START, DATA, FETCH, DONE).
- Each wait state on the bus adds one cycle per access.
- stall is low in exactly one cycle per step, never two consecutive.
- inst and load_data are valid from the DONE cycle onward and stay unchanged until the next capture.
- Timeout completion: the access ends in the TIMEOUT-th cycle of bus_req. bus_err is visible the following cycle.

## Test plan
- Reset, then fetch-only steps, pc=0x100, slave acks immediately with 0x00500093 → bus_req high in 1 cycle at addr 0x100 with we=0; inst=0x00500093 and stall=0 in the 3rd cycle after reset release; a pulse of stall=0 repeats every 3 cycles.
- Load step, address=0x2000, pc=0x104, slave returns 0xDEADBEEF then 0x00000013, each with 2 wait states:
  - First access is 0x2000 with we=0, then 0x104.
  - load_data=0xDEADBEEF.
  - Step is 8 cycles.
- Store step, address=0x2004, store_data=0x12345678:
  - bus_we=1 and bus_wdata=0x12345678 are held through the waits.
  - load_data is unchanged.
  - The fetch follows with we=0.
- Slave never acks, TIMEOUT=4:
  - bus_req is high for exactly 4 cycles per access.
  - inst=0x00000013.
  - bus_err=1 and stays 1 until reset.
- Reset asserted during a DATA wait: bus_req=0, stall=1 and inst=NOP in the same cycle; an ack pulse during reset is ignored; after release the FSM restarts at START.
- mem_load=mem_store=1, address=0x3000 → a single write to 0x3000, load_data unchanged, then the fetch.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises one data access and one instruction
// fetch per core step onto a shared bus, stalling the core until both finish.
module mem_arbiter #(
  parameter int              XLEN    = 32,
  parameter int              TIMEOUT = 64,
  parameter logic [XLEN-1:0] NOP     = XLEN'(32'h00000013)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            mem_load,
  input  logic            mem_store,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] load_data,
  output logic            stall,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            bus_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_DATA  = 2'd1,
    S_FETCH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_load_data;
  logic            r_stall;
  logic            r_bus_req;
  logic            r_bus_we;
  logic [XLEN-1:0] r_bus_addr;
  logic [XLEN-1:0] r_bus_wdata;
  logic            r_bus_err;

  logic w_ack;
  logic w_to;
  logic w_done;

  // An ack only counts while a request is actually on the bus.
  assign w_ack = r_bus_req & bus_ack;

  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign w_to = r_bus_req & ~bus_ack & (r_cnt == CW'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign w_to = 1'b0;
    end
  endgenerate

  assign w_done = w_ack | w_to;

  assign inst      = r_inst;
  assign load_data = r_load_data;
  assign stall     = r_stall;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_err   = r_bus_err;

  // Step sequencer: START -> [DATA] -> FETCH -> DONE, all outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_START;
      r_cnt       <= {CW{1'b0}};
      r_inst      <= NOP;
      r_load_data <= {XLEN{1'b0}};
      r_stall     <= 1'b1;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= {XLEN{1'b0}};
      r_bus_wdata <= {XLEN{1'b0}};
      r_bus_err   <= 1'b0;
    end else begin
      case (r_state)
        S_START: begin
          r_stall   <= 1'b1;
          r_bus_req <= 1'b1;
          r_cnt     <= {CW{1'b0}};
          if (mem_load | mem_store) begin
            r_state     <= S_DATA;
            r_bus_addr  <= address;
            r_bus_we    <= mem_store;
            r_bus_wdata <= store_data;
          end else begin
            r_state    <= S_FETCH;
            r_bus_addr <= pc;
            r_bus_we   <= 1'b0;
          end
        end
        S_DATA: begin
          if (w_done) begin
            // A store (including load+store together) never touches load_data.
            if (!r_bus_we) begin
              r_load_data <= w_ack ? bus_rdata : {XLEN{1'b0}};
            end
            if (w_to) begin
              r_bus_err <= 1'b1;
            end
            r_state    <= S_FETCH;
            r_bus_addr <= pc;
            r_bus_we   <= 1'b0;
            r_cnt      <= {CW{1'b0}};
          end else if (TIMEOUT > 0) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_FETCH: begin
          if (w_done) begin
            r_inst <= w_ack ? bus_rdata : NOP;
            if (w_to) begin
              r_bus_err <= 1'b1;
            end
            r_state   <= S_DONE;
            r_bus_req <= 1'b0;
            r_stall   <= 1'b0;
          end else if (TIMEOUT > 0) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_START;
          r_stall <= 1'b1;
        end
        default: begin
          r_state   <= S_START;
          r_stall   <= 1'b1;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
